// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//
// Store path of the MEM stage. A store is narrowed to byte / halfword / word,
// replicated across the byte lanes and given matching byte enables, then
// written to data memory with a req/ack handshake. While the write is
// outstanding the pipeline is stalled. Address errors (AdES) and ack timeouts
// are reported as one-cycle pulses, with the faulting address kept in badvaddr.
//
// Optional feature macro: STORE_MISALIGN_CHECK_EN
//   defined   : misaligned half/word stores and size 2'b11 raise exc_ades.
//   undefined : no alignment check; the address is forced to natural
//               alignment, size 2'b11 is treated as a word, exc_ades = 0.
//
// Parameters
//   ACK_TIMEOUT : REQ cycles without mem_ack before bus_err (>= 2)
//   BIG_ENDIAN  : 0 = little-endian lane order, 1 = big-endian
//
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   st_valid/st_size/
//   st_addr/st_data       : store request from the MEM stage
//   st_ready              : a store is accepted this cycle
//   stall                 : hold the pipeline (write outstanding)
//   st_done               : one-cycle pulse, write completed
//   exc_ades              : one-cycle pulse, store address error
//   bus_err               : one-cycle pulse, ack timeout
//   badvaddr              : last faulting byte address
//   mem_req/mem_addr/
//   mem_wdata/mem_be      : write request to data memory
//   mem_ack               : memory accepted the write
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        stall,
  output logic        st_done,
  output logic        exc_ades,
  output logic        bus_err,
  output logic [31:0] badvaddr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int             CW       = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic [3:0]    mem_be_reg;
  logic [31:0]   byte_addr_reg;
  logic [31:0]   badvaddr_reg;
  logic          st_done_reg;
  logic          bus_err_reg;

  logic [1:0]    eff_size;
  logic [31:0]   eff_addr;
  logic          fault;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic          accept;
  logic          ack_hit;
  logic          timeout_hit;

  // ---------------------------------------------------------------------------
  // Request decode: effective size/address and fault detection.
  // ---------------------------------------------------------------------------
  always_comb begin
    eff_size = st_size;
    eff_addr = st_addr;
    fault    = 1'b0;
`ifdef STORE_MISALIGN_CHECK_EN
    case (st_size)
      2'b01:   fault = st_addr[0];
      2'b10:   fault = |st_addr[1:0];
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
`else
    // Without the check the access is silently snapped to natural alignment.
    case (st_size)
      2'b01: eff_addr[0] = 1'b0;
      2'b10, 2'b11: begin
        eff_size      = 2'b10;
        eff_addr[1:0] = 2'b00;
      end
      default: ;
    endcase
`endif
  end

  // ---------------------------------------------------------------------------
  // Lane placement. Data is replicated on every lane so only the enables
  // depend on endianness.
  // ---------------------------------------------------------------------------
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = st_data;
    case (eff_size)
      2'b00: begin
        // Big-endian mirrors the byte lane: index 3 - a == ~a for 2 bits.
        be_calc    = 4'b0001 << (BIG_ENDIAN ? ~eff_addr[1:0] : eff_addr[1:0]);
        wdata_calc = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_calc    = (eff_addr[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
        wdata_calc = {2{st_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = st_data;
      end
    endcase
  end

  assign accept      = (state_reg == S_IDLE) && st_valid;
  assign ack_hit     = (state_reg == S_REQ) && mem_ack;
  // An ack in the final counted cycle wins over the timeout.
  assign timeout_hit = (state_reg == S_REQ) && !mem_ack && (cnt_reg == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs. mem_req is decoded from the state
  // register so an asynchronous reset drops it immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    stall      = 1'b0;
    st_ready   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        st_ready = 1'b1;
        if (accept && !fault) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack || (cnt_reg == CNT_LAST)) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      byte_addr_reg <= '0;
      badvaddr_reg  <= '0;
      st_done_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      st_done_reg <= ack_hit;
      bus_err_reg <= timeout_hit;

      // Counter restarts on every entry into REQ.
      if (state_reg == S_REQ) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end

      if (accept && !fault) begin
        mem_addr_reg  <= {eff_addr[31:2], 2'b00};
        mem_wdata_reg <= wdata_calc;
        mem_be_reg    <= be_calc;
        byte_addr_reg <= eff_addr;
      end

      if (accept && fault) begin
        badvaddr_reg <= st_addr;
      end else if (timeout_hit) begin
        badvaddr_reg <= byte_addr_reg;
      end
    end
  end

`ifdef STORE_MISALIGN_CHECK_EN
  logic exc_ades_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_ades_reg <= 1'b0;
    end else begin
      exc_ades_reg <= accept && fault;
    end
  end

  assign exc_ades = exc_ades_reg;
`else
  assign exc_ades = 1'b0;
`endif

  assign st_done   = st_done_reg;
  assign bus_err   = bus_err_reg;
  assign badvaddr  = badvaddr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//
// Two store_unit instances (little- and big-endian, ACK_TIMEOUT = 4) share the
// same stimulus. A transaction-level model derives the expected outputs for
// each cycle from the store rules; one compare process checks both DUTs every
// cycle. Directed stores with literal expectations pin the model, then a
// randomized run with random ack delays, idle gaps and ignored requests.
// -----------------------------------------------------------------------------
module tb_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_ack;

  logic        st_ready_le, stall_le, st_done_le, exc_ades_le, bus_err_le, mem_req_le;
  logic [31:0] badvaddr_le, mem_addr_le, mem_wdata_le;
  logic [3:0]  mem_be_le;
  logic        st_ready_be, stall_be, st_done_be, exc_ades_be, bus_err_be, mem_req_be;
  logic [31:0] badvaddr_be, mem_addr_be, mem_wdata_be;
  logic [3:0]  mem_be_be;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Expected state after the next active edge.
  bit          exp_req, exp_done, exp_exc, exp_berr;
  logic [31:0] exp_badv, exp_maddr, exp_wdata;
  logic [3:0]  exp_be_le, exp_be_be;

  always #5 clk = ~clk;

  store_unit #(.ACK_TIMEOUT(T), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready_le),
    .stall(stall_le), .st_done(st_done_le), .exc_ades(exc_ades_le),
    .bus_err(bus_err_le), .badvaddr(badvaddr_le), .mem_req(mem_req_le),
    .mem_addr(mem_addr_le), .mem_wdata(mem_wdata_le), .mem_be(mem_be_le),
    .mem_ack(mem_ack)
  );

  store_unit #(.ACK_TIMEOUT(T), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready_be),
    .stall(stall_be), .st_done(st_done_be), .exc_ades(exc_ades_be),
    .bus_err(bus_err_be), .badvaddr(badvaddr_be), .mem_req(mem_req_be),
    .mem_addr(mem_addr_be), .mem_wdata(mem_wdata_be), .mem_be(mem_be_be),
    .mem_ack(mem_ack)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the store rules.
  // ---------------------------------------------------------------------------
  function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
`ifdef STORE_MISALIGN_CHECK_EN
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] model_size(input logic [1:0] sz);
    return (sz == 2'd3) ? 2'd2 : sz;
  endfunction

  function automatic logic [31:0] model_addr(input logic [1:0] sz, input logic [31:0] a);
    case (model_size(sz))
      2'd1:    return a - (a % 2);
      2'd2:    return a - (a % 4);
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (model_size(sz))
      2'd0:    return (d % 256) * 32'h0101_0101;
      2'd1:    return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a, input bit big);
    int ofs;
    int lane;
    ofs = int'(a % 4);
    case (model_size(sz))
      2'd0: begin
        lane = big ? 3 - ofs : ofs;
        return 4'(1 << lane);
      end
      2'd1: begin
        lane = (ofs >= 2) ? 2 : 0;          // lowest lane of the pair (LE)
        return big ? 4'(3 << (2 - lane)) : 4'(3 << lane);
      end
      default: return 4'hF;
    endcase
  endfunction

  task automatic exp_reset();
    exp_req = 0; exp_done = 0; exp_exc = 0; exp_berr = 0;
    exp_badv = '0; exp_maddr = '0; exp_wdata = '0; exp_be_le = '0; exp_be_be = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model expectation.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("le_mem_req",  {31'd0, mem_req_le},  {31'd0, exp_req});
      chk("le_stall",    {31'd0, stall_le},    {31'd0, exp_req});
      chk("le_st_ready", {31'd0, st_ready_le}, {31'd0, !exp_req});
      chk("le_st_done",  {31'd0, st_done_le},  {31'd0, exp_done});
      chk("le_exc_ades", {31'd0, exc_ades_le}, {31'd0, exp_exc});
      chk("le_bus_err",  {31'd0, bus_err_le},  {31'd0, exp_berr});
      chk("le_badvaddr", badvaddr_le,          exp_badv);
      chk("le_mem_addr", mem_addr_le,          exp_maddr);
      chk("le_wdata",    mem_wdata_le,         exp_wdata);
      chk("le_be",       {28'd0, mem_be_le},   {28'd0, exp_be_le});
      chk("be_mem_req",  {31'd0, mem_req_be},  {31'd0, exp_req});
      chk("be_stall",    {31'd0, stall_be},    {31'd0, exp_req});
      chk("be_st_ready", {31'd0, st_ready_be}, {31'd0, !exp_req});
      chk("be_st_done",  {31'd0, st_done_be},  {31'd0, exp_done});
      chk("be_exc_ades", {31'd0, exc_ades_be}, {31'd0, exp_exc});
      chk("be_bus_err",  {31'd0, bus_err_be},  {31'd0, exp_berr});
      chk("be_badvaddr", badvaddr_be,          exp_badv);
      chk("be_mem_addr", mem_addr_be,          exp_maddr);
      chk("be_wdata",    mem_wdata_be,         exp_wdata);
      chk("be_be",       {28'd0, mem_be_be},   {28'd0, exp_be_be});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      st_valid = 1'b0;
      mem_ack  = 1'($urandom);           // ignored while idle
      @(negedge clk);
    end
  endtask

  // One store; called at a negedge while the unit is idle. ack_at is the REQ
  // cycle index (from 0) in which mem_ack is raised, negative for never.
  // Returns at the negedge of the completion / fault cycle.
  task automatic run_store(input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] data, input int ack_at,
                           input bit lit_en, input logic [31:0] lit_ma,
                           input logic [3:0] lit_le, input logic [3:0] lit_be,
                           input logic [31:0] lit_wd);
    bit          flt;
    bit          over;
    logic [31:0] ea;
    flt = model_fault(sz, addr);
    ea  = model_addr(sz, addr);
    st_valid = 1'b1; st_size = sz; st_addr = addr; st_data = data;
    mem_ack  = 1'($urandom);
    if (flt) begin
      exp_exc  = 1;
      exp_badv = addr;
    end else begin
      exp_req   = 1;
      exp_maddr = ea - (ea % 4);
      exp_wdata = model_wdata(sz, data);
      exp_be_le = model_be(sz, ea, 1'b0);
      exp_be_be = model_be(sz, ea, 1'b1);
    end
    @(negedge clk);
    if (flt) begin
      st_valid = 1'b0; mem_ack = 1'b0; exp_exc = 0;
      $display("txn size=%0d addr=%h data=%h -> ades", sz, addr, data);
      return;
    end
    if (lit_en) begin
      chk("lit_mem_addr", mem_addr_le, lit_ma);
      chk("lit_be_le",    {28'd0, mem_be_le}, {28'd0, lit_le});
      chk("lit_be_be",    {28'd0, mem_be_be}, {28'd0, lit_be});
      chk("lit_wdata",    mem_wdata_le, lit_wd);
    end
    over = 0;
    for (int k = 0; k < T + 2 && !over; k++) begin
      mem_ack  = (k == ack_at);
      // A second store during REQ must be ignored.
      st_valid = 1'($urandom);
      st_size  = 2'($urandom);
      st_addr  = $urandom;
      st_data  = $urandom;
      if (k == ack_at) begin
        exp_req = 0; exp_done = 1; over = 1;
      end else if (k == T - 1) begin
        exp_req = 0; exp_berr = 1; exp_badv = ea; over = 1;
      end
      @(negedge clk);
    end
    if (!over) chk("txn_bound", 32'd0, 32'd1);
    st_valid = 1'b0; mem_ack = 1'b0;
    exp_done = 0; exp_berr = 0;
    $display("txn size=%0d addr=%h data=%h ack_at=%0d", sz, addr, data, ack_at);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_size = 2'd0; st_addr = '0; st_data = '0; mem_ack = 1'b0;
    exp_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_st_ready", {31'd0, st_ready_le}, 32'd1);
    chk("rst_mem_req",  {31'd0, mem_req_le},  32'd0);
    chk("rst_badvaddr", badvaddr_be,          32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Directed stores with literal expectations.
    run_store(2'd0, 32'h0000_1003, 32'h1234_56AB, 0, 1, 32'h1000, 4'b1000, 4'b0001, 32'hABAB_ABAB);
    chk("lit_done", {31'd0, st_done_le}, 32'd1);
    run_store(2'd1, 32'h0000_1002, 32'h0000_BEEF, 0, 1, 32'h1000, 4'b1100, 4'b0011, 32'hBEEF_BEEF);
    run_store(2'd0, 32'h0000_1000, 32'h0000_0077, 0, 1, 32'h1000, 4'b0001, 4'b1000, 32'h7777_7777);
    run_store(2'd1, 32'h0000_1000, 32'hAAAA_5A5A, 1, 1, 32'h1000, 4'b0011, 4'b1100, 32'h5A5A_5A5A);

`ifdef STORE_MISALIGN_CHECK_EN
    run_store(2'd2, 32'h0000_2002, 32'hDEAD_BEEF, 0, 0, 32'h0, 4'h0, 4'h0, 32'h0);
    chk("ades_pulse", {31'd0, exc_ades_le}, 32'd1);
    chk("ades_badv",  badvaddr_le, 32'h0000_2002);
    chk("ades_ready", {31'd0, st_ready_le}, 32'd1);
    run_store(2'd3, 32'h0000_2000, 32'h0, 0, 0, 32'h0, 4'h0, 4'h0, 32'h0);
`else
    run_store(2'd2, 32'h0000_2002, 32'hDEAD_BEEF, 0, 1, 32'h2000, 4'b1111, 4'b1111, 32'hDEAD_BEEF);
    run_store(2'd1, 32'h0000_2003, 32'h0000_1234, 0, 1, 32'h2000, 4'b1100, 4'b0011, 32'h1234_1234);
    run_store(2'd3, 32'h0000_2005, 32'hCAFE_F00D, 0, 1, 32'h2004, 4'b1111, 4'b1111, 32'hCAFE_F00D);
`endif

    // Timeout: mem_req for T cycles then bus_err.
    run_store(2'd2, 32'h0000_4000, 32'h1111_2222, -1, 0, 32'h0, 4'h0, 4'h0, 32'h0);
    chk("berr_pulse", {31'd0, bus_err_le}, 32'd1);
    chk("berr_badv",  badvaddr_le, 32'h0000_4000);
    chk("berr_nodone", {31'd0, st_done_le}, 32'd0);
    // Ack delayed 3 cycles: same cycle as the timeout, ack wins.
    run_store(2'd2, 32'h0000_5000, 32'h3333_4444, 3, 0, 32'h0, 4'h0, 4'h0, 32'h0);
    chk("late_ack_done", {31'd0, st_done_be}, 32'd1);
    chk("late_ack_berr", {31'd0, bus_err_be}, 32'd0);

    // Reset in the middle of REQ.
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h0000_3000; st_data = 32'h5555_6666; mem_ack = 1'b0;
    exp_req = 1; exp_maddr = 32'h3000; exp_wdata = 32'h5555_6666; exp_be_le = 4'hF; exp_be_be = 4'hF;
    @(negedge clk);
    st_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_reset();
    #1;
    chk("async_mem_req",  {31'd0, mem_req_le},  32'd0);
    chk("async_st_ready", {31'd0, st_ready_be}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_store(2'd2, 32'h0000_3004, 32'h7777_8888, 1, 1, 32'h3004, 4'hF, 4'hF, 32'h7777_8888);
    chk("post_rst_done", {31'd0, st_done_le}, 32'd1);

    // Randomized stores.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      run_store(2'($urandom), $urandom, $urandom, (r == 5) ? -1 : r,
                0, 32'h0, 4'h0, 4'h0, 32'h0);
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-path counterpart of the load-path sign/zero extension in the MIPS datapath: narrows a 32-bit register value to byte, halfword or word and places it on the correct byte lanes.
- Generates the matching byte enables and runs a req/ack write handshake to data memory.
- Sits between the MEM stage and the data-memory port.
- Stalls the pipeline while a write is outstanding and reports address-error (AdES) and bus-timeout conditions.

Parameters:
- ACK_TIMEOUT, 16, number of cycles in REQ without mem_ack before bus_err; must be >= 2.
- BIG_ENDIAN, 0, byte-lane order: 0 = little-endian, 1 = big-endian.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  MEM stage presents a store.
- st_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- st_addr  in  32  byte address.
- st_data  in  32  register value to store; only the low bits are used for byte/half.
- st_ready  out  1  unit accepts a store this cycle.
- stall  out  1  pipeline hold request.
- st_done  out  1  one-cycle pulse when the write completes.
- exc_ades  out  1  one-cycle pulse on store address error.
- bus_err  out  1  one-cycle pulse on ack timeout.
- badvaddr  out  32  faulting address; holds its value until the next fault.
- mem_req  out  1  write request to data memory.
- mem_addr  out  32  word address, {st_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables; bit i enables wdata[8i+7:8i].
- mem_ack  in  1  memory has accepted the write.

Behaviour:
- Reset: all outputs 0 except st_ready = 1; state IDLE; timeout counter 0.
- Reset asserted mid-transaction drops mem_req immediately, and no st_done is produced.
- States: IDLE, REQ.
- IDLE:
  - st_ready = 1, stall = 0.
  - Accept on st_valid.
  - If the access is misaligned, or st_size = 11: next cycle exc_ades = 1 for one cycle, badvaddr <= st_addr, stay IDLE, no mem_req.
  - Otherwise register mem_addr, mem_wdata and mem_be, then enter REQ.
- Misaligned means: half with addr[0] != 0, or word with addr[1:0] != 0.
- Lane mapping, little-endian (BIG_ENDIAN = 0), with a = addr[1:0]:
  - byte: be = 1 << a; wdata = {4{data[7:0]}}.
  - half: be = a[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - word: be = 1111; wdata = data.
- Big-endian (BIG_ENDIAN = 1): byte lane index = 3 - a; half be = a[1] ? 0011 : 1100.
- REQ:
  - mem_req = 1, stall = 1, st_ready = 0.
  - mem_addr, mem_wdata and mem_be are held stable.
  - The counter increments each cycle in REQ.
  - On mem_ack: the next cycle has mem_req = 0, st_done = 1 for one cycle, state IDLE. st_ready = 1 in that same cycle, so back-to-back stores have one dead cycle minimum between mem_req pulses.
  - On reaching ACK_TIMEOUT - 1 without mem_ack: bus_err = 1 for one cycle, badvaddr <= the byte address, drop mem_req, return to IDLE.
  - If mem_ack arrives in the same cycle the timeout is reached, the ack wins: st_done is produced, no bus_err.
- mem_ack while in IDLE is ignored.
- st_valid while in REQ is ignored; the MEM stage is held by stall.
- Latency: an ack on the first REQ cycle gives st_done 2 cycles after acceptance.

Optional Feature:
- Macro STORE_MISALIGN_CHECK_EN.
- Defined: misaligned half/word stores raise exc_ades as described above.
- Undefined:
  - No alignment check; exc_ades is tied to 0.
  - The address is forced to natural alignment: half clears addr[0], word clears addr[1:0].
  - The access then proceeds normally.
  - st_size = 11 is treated as a word access.

Test Plan:
- Little-endian stores, each acked in 1 cycle:
  - sb addr 0x1003, data 0x123456AB -> mem_addr 0x1000, be 1000, wdata 0xABABABAB.
  - sh addr 0x1002, data 0x0000BEEF -> be 1100, wdata 0xBEEFBEEF.
- BIG_ENDIAN = 1: sb addr 0x1000 -> be 1000; sh addr 0x1000 -> be 1100.
- sw addr 0x2002 with STORE_MISALIGN_CHECK_EN defined -> exc_ades pulse, badvaddr 0x2002, mem_req never asserted, st_ready stays 1.
- ACK_TIMEOUT = 4, mem_ack never asserted -> mem_req high 4 cycles, bus_err pulse, st_done 0, back to IDLE.
- mem_ack delayed 3 cycles:
  - stall high throughout, mem outputs stable.
  - st_done pulses once.
  - A second st_valid during REQ is not accepted until after st_done.
- rst asserted during REQ -> mem_req drops asynchronously, st_ready = 1, no st_done; a new sw afterwards completes normally.
